// File: rtl/hc8_rom_loader_pkg.sv
// Shared constants for the HC8 serial program loader: sync byte, ROM geometry,
// loader and UART receiver state encodings.
package hc8_rom_loader_pkg;

    localparam logic [7:0]  HC8_SYNC_BYTE  = 8'h55;
    localparam int unsigned HC8_ROM_ADDR_W = 12;
    localparam int unsigned HC8_LEN_W      = 12;

    localparam logic [2:0] LD_IDLE  = 3'd0;
    localparam logic [2:0] LD_LEN_H = 3'd1;
    localparam logic [2:0] LD_LEN_L = 3'd2;
    localparam logic [2:0] LD_DATA  = 3'd3;
    localparam logic [2:0] LD_CSUM  = 3'd4;
    localparam logic [2:0] LD_DONE  = 3'd5;
    localparam logic [2:0] LD_ERR   = 3'd6;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    // States in which a frame is in flight.
    function automatic logic ld_busy(input logic [2:0] s);
        return (s == LD_LEN_H) || (s == LD_LEN_L) || (s == LD_DATA) || (s == LD_CSUM);
    endfunction

endpackage

// File: rtl/hc8_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, false-start rejection at half bit,
// mid-bit sampling, single-cycle byte_valid or frame_err after the stop sample.
module hc8_uart_rx
    import hc8_rom_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rxd_sync_q;
                    ferr_d  = !rxd_sync_q;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/hc8_rom_loader.sv
// HC8 program loader: parses 55/LEN_H/LEN_L/data/CSUM frames from the UART,
// writes the image into program ROM and holds the CPU in reset until a verified load.
module hc8_rom_loader
    import hc8_rom_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned ADDR_W       = HC8_ROM_ADDR_W
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              rxd,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_wdata,
    output logic              cpu_nreset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    logic                 rx_valid, rx_ferr;
    logic [7:0]           rx_data;
    logic [2:0]           state_q, state_d;
    logic [3:0]           len_hi_q, len_hi_d;
    logic [HC8_LEN_W-1:0] rem_q, rem_d;
    logic [HC8_LEN_W-1:0] len_c;
    logic [7:0]           sum_q, sum_d;
    logic [7:0]           csum_c;
    logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
    logic [7:0]           rom_wdata_q, rom_wdata_d;
    logic                 rom_we_q, rom_we_d;
    logic                 cpu_nreset_q, cpu_nreset_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    hc8_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .nReset     (nReset),
        .rxd        (rxd),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    assign len_c  = {len_hi_q, rx_data};
    assign csum_c = sum_q + rx_data;

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        rem_d        = rem_q;
        sum_d        = sum_q;
        rom_addr_d   = rom_addr_q;
        rom_wdata_d  = rom_wdata_q;
        rom_we_d     = 1'b0;
        cpu_nreset_d = cpu_nreset_q;
        done_d       = done_q;
        err_d        = err_q;
        // Advance only when more bytes follow, so the address stays within 0..N-1.
        if (rom_we_q && (state_q == LD_DATA)) rom_addr_d = rom_addr_q + ADDR_W'(1);
        if (rx_ferr && ld_busy(state_q)) begin
            state_d      = LD_ERR;
            err_d        = 1'b1;
            cpu_nreset_d = 1'b0;
        end else if (rx_valid) begin
            case (state_q)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (rx_data == HC8_SYNC_BYTE) begin
                        state_d      = LD_LEN_H;
                        cpu_nreset_d = 1'b0;
                        done_d       = 1'b0;
                        err_d        = 1'b0;
                    end
                end
                LD_LEN_H: begin
                    if (rx_data[7:4] != 4'h0) begin
                        state_d = LD_ERR;
                        err_d   = 1'b1;
                    end else begin
                        len_hi_d = rx_data[3:0];
                        state_d  = LD_LEN_L;
                    end
                end
                LD_LEN_L: begin
                    rem_d      = len_c;
                    sum_d      = 8'h00;
                    rom_addr_d = '0;
                    state_d    = (len_c == '0) ? LD_CSUM : LD_DATA;
                end
                LD_DATA: begin
                    rom_we_d    = 1'b1;
                    rom_wdata_d = rx_data;
                    sum_d       = csum_c;
                    rem_d       = rem_q - HC8_LEN_W'(1);
                    if (rem_q == HC8_LEN_W'(1)) state_d = LD_CSUM;
                end
                LD_CSUM: begin
                    if (csum_c == 8'h00) begin
                        state_d      = LD_DONE;
                        done_d       = 1'b1;
                        cpu_nreset_d = 1'b1;
                    end else begin
                        state_d = LD_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = LD_IDLE;
            endcase
        end
        busy_d = ld_busy(state_d);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= LD_IDLE;
            len_hi_q     <= 4'h0;
            rem_q        <= '0;
            sum_q        <= 8'h00;
            rom_addr_q   <= '0;
            rom_wdata_q  <= 8'h00;
            rom_we_q     <= 1'b0;
            cpu_nreset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            rem_q        <= rem_d;
            sum_q        <= sum_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            rom_we_q     <= rom_we_d;
            cpu_nreset_q <= cpu_nreset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_wdata  = rom_wdata_q;
    assign cpu_nreset = cpu_nreset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hc8_rom_loader.sv
// Bench for hc8_rom_loader: directed frames plus random frames, checked against
// an expected-write scoreboard and frame-level status expectations.
module tb_hc8_rom_loader;

    localparam int unsigned CPB = 16;

    typedef logic [7:0] byteq_t[$];
    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        rxd = 1'b1;
    logic        rom_we;
    logic [11:0] rom_addr;
    logic [7:0]  rom_wdata;
    logic        cpu_nreset, busy, done, err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [7:0]  mem [16];

    always #5 clk = ~clk;

    hc8_rom_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(12)) dut (
        .clk        (clk),
        .nReset     (nReset),
        .rxd        (rxd),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .cpu_nreset (cpu_nreset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write must match the next expected (addr, data); status flags obey their rules.
    always @(negedge clk) begin
        check("done_err_exclusive", 32'(done && err), 32'd0);
        check("cpu_released_only_when_done", 32'(cpu_nreset), 32'(done));
        if (rom_we) begin
            wr_count++;
            mem[rom_addr[3:0]] = rom_wdata;
            if (exp_q.size() == 0) begin
                check("unexpected_rom_we_addr", 32'(rom_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("rom_addr", 32'(rom_addr), 32'(mon_e.addr));
                check("rom_wdata", 32'(rom_wdata), 32'(mon_e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(posedge clk);
        rxd = 1'b1;
        repeat (CPB + $urandom_range(0, 6)) @(posedge clk);
    endtask

    task automatic send_list(input byteq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    task automatic expect_writes(input byteq_t d);
        foreach (d[i]) exp_q.push_back({12'(i), d[i]});
    endtask

    task automatic check_status(input logic e_done, input logic e_err, input logic e_busy);
        check("done", 32'(done), 32'(e_done));
        check("err", 32'(err), 32'(e_err));
        check("cpu_nreset", 32'(cpu_nreset), 32'(e_done));
        check("busy", 32'(busy), 32'(e_busy));
    endtask

    // Random frame: optional idle garbage, then a good, bad-checksum, bad-LEN_H or framing-error load.
    task automatic random_frame();
        int          n    = int'($urandom_range(0, 5));
        int          kind = int'($urandom_range(0, 9));
        int          sum  = 0;
        int          fe_at = -1;
        logic [7:0]  b;
        logic [7:0]  csum;
        byteq_t      d;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'h55) b = 8'h54;
            send_byte(b, 1'($urandom_range(0, 3) != 0));
        end
        send_byte(8'h55, 1'b1);
        check_status(1'b0, 1'b0, 1'b1);
        if (kind == 0) begin
            send_byte({4'($urandom_range(1, 15)), 4'($urandom)}, 1'b1);
            check_status(1'b0, 1'b1, 1'b0);
            return;
        end
        send_byte(8'h00, 1'b1);
        send_byte(8'(n), 1'b1);
        if (kind == 1 && n > 0) fe_at = int'($urandom_range(0, n - 1));
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i == fe_at) begin
                send_byte(b, 1'b0);
                check_status(1'b0, 1'b1, 1'b0);
                return;
            end
            d = {b};
            exp_q.push_back({12'(i), b});
            sum += int'(b);
            send_byte(b, 1'b1);
        end
        csum = 8'((256 - (sum % 256)) % 256);
        if (kind == 2) csum = csum ^ 8'($urandom_range(1, 255));
        send_byte(csum, 1'b1);
        check_status(((sum + int'(csum)) % 256) == 0, ((sum + int'(csum)) % 256) != 0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rom_we", 32'(rom_we), 32'd0);
        check("reset_rom_addr", 32'(rom_addr), 32'd0);
        check("reset_rom_wdata", 32'(rom_wdata), 32'd0);
        check_status(1'b0, 1'b0, 1'b0);
        nReset = 1'b1;
        repeat (2 * CPB) @(posedge clk);

        // Good 3-byte load.
        send_list('{8'h55});
        check_status(1'b0, 1'b0, 1'b1);
        expect_writes('{8'hA1, 8'hB2, 8'hC3});
        send_list('{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hEA});
        check_status(1'b1, 1'b0, 1'b0);
        check("t1_write_count", 32'(wr_count), 32'd3);
        check("t1_mem0", 32'(mem[0]), 32'hA1);
        check("t1_mem1", 32'(mem[1]), 32'hB2);
        check("t1_mem2", 32'(mem[2]), 32'hC3);

        // Sync value inside the data field is plain data.
        expect_writes('{8'h55, 8'h55});
        send_list('{8'h55, 8'h00, 8'h02, 8'h55, 8'h55, 8'h56});
        check_status(1'b1, 1'b0, 1'b0);

        // Bad checksum, then recovery.
        expect_writes('{8'h10, 8'h20});
        send_list('{8'h55, 8'h00, 8'h02, 8'h10, 8'h20, 8'h00});
        check_status(1'b0, 1'b1, 1'b0);
        send_list('{8'h55});
        check_status(1'b0, 1'b0, 1'b1);
        expect_writes('{8'h7F});
        send_list('{8'h00, 8'h01, 8'h7F, 8'h81});
        check_status(1'b1, 1'b0, 1'b0);

        // Idle garbage, a short low glitch, then a zero-length load.
        send_list('{8'h00, 8'hFF, 8'h12});
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        check_status(1'b1, 1'b0, 1'b0);
        send_list('{8'h55, 8'h00, 8'h00, 8'h00});
        check_status(1'b1, 1'b0, 1'b0);
        check("t3_write_count", 32'(wr_count), 32'd8);

        // Framing error in DATA.
        expect_writes('{8'h01});
        send_list('{8'h55, 8'h00, 8'h03, 8'h01});
        send_byte(8'h02, 1'b0);
        check_status(1'b0, 1'b1, 1'b0);
        check("t4_write_count", 32'(wr_count), 32'd9);

        // Oversized LEN_H.
        send_list('{8'h55, 8'h10});
        check_status(1'b0, 1'b1, 1'b0);

        // Reset in the middle of the second data byte.
        expect_writes('{8'h11});
        send_list('{8'h55, 8'h00, 8'h05, 8'h11});
        rxd = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #2 nReset = 1'b0;
        #1;
        check("t6_rom_we", 32'(rom_we), 32'd0);
        check("t6_rom_addr", 32'(rom_addr), 32'd0);
        check("t6_rom_wdata", 32'(rom_wdata), 32'd0);
        check_status(1'b0, 1'b0, 1'b0);
        rxd = 1'b1;
        repeat (4 * CPB) @(posedge clk);
        nReset = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        check_status(1'b0, 1'b0, 1'b0);
        expect_writes('{8'hAA});
        send_list('{8'h55, 8'h00, 8'h01, 8'hAA, 8'h56});
        check_status(1'b1, 1'b0, 1'b0);
        check("t6_mem0", 32'(mem[0]), 32'hAA);

        for (int f = 0; f < 25; f++) random_frame();

        repeat (4 * CPB) @(posedge clk);
        check("expected_writes_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
